// File: rtl/sram64x4_rr_ctrl_pkg.sv
// Shared types and default geometry for the two-port round-robin SRAM controller.
package sram64x4_rr_ctrl_pkg;

  localparam int unsigned DefAddrWidth  = 6;
  localparam int unsigned DefDataWidth  = 4;
  localparam int unsigned DefWmaskWidth = 2;

  typedef enum logic {
    StInit,
    StArb
  } state_e;

  typedef logic port_idx_t;

endpackage

// File: rtl/sram64x4_rr_ctrl_if.sv
// One client request/response channel: valid/ready request plus unthrottled read return.
interface sram64x4_rr_ctrl_if
  import sram64x4_rr_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned WMASK_WIDTH = DefWmaskWidth
);
  logic                   valid;
  logic                   ready;
  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic                   rvalid;
  logic [DATA_WIDTH-1:0]  rdata;

  modport master (
    output valid, we, wmask, addr, din,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, wmask, addr, din,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/sram64x4_rr_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; ties go to rr_ptr, which then moves off the winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = rr_ptr_q ? 2'b10 : 2'b01;
    end
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = grant[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: rtl/sram64x4_rr_ctrl.sv
// Shares one single-port SRAM macro between two clients; zero-fills the array after reset.
module sram64x4_rr_ctrl
  import sram64x4_rr_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DefAddrWidth,
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned WMASK_WIDTH   = DefWmaskWidth,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   init_done,
  sram64x4_rr_ctrl_if.slave      p0,
  sram64x4_rr_ctrl_if.slave      p1,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(Depth - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    rd_pend_q, rd_pend_d;
  port_idx_t               rd_port_q, rd_port_d;
  logic                    in_arb;
  logic [1:0]              req;
  logic [1:0]              grant;
  logic                    accept;

  assign in_arb = (state_q == StArb);
  assign req    = {p1.valid, p0.valid} & {2{in_arb}};
  assign accept = |req;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rd_pend_d  = 1'b0;
    rd_port_d  = rd_port_q;
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    unique case (state_q)
      StInit: begin
        sram_we    = 1'b1;
        sram_wmask = '1;
        sram_addr  = init_cnt_q;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == LastAddr) begin
          state_d = StArb;
        end
      end
      StArb: begin
        // Idle cycles leave the macro doing a harmless read of address 0.
        if (grant[0]) begin
          sram_we    = p0.we;
          sram_wmask = p0.wmask;
          sram_addr  = p0.addr;
          sram_din   = p0.din;
          rd_pend_d  = ~p0.we;
          rd_port_d  = 1'b0;
        end else if (grant[1]) begin
          sram_we    = p1.we;
          sram_wmask = p1.wmask;
          sram_addr  = p1.addr;
          sram_din   = p1.din;
          rd_pend_d  = ~p1.we;
          rd_port_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_ON_RESET ? StInit : StArb;
      init_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_port_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_port_q  <= rd_port_d;
    end
  end

  assign init_done = in_arb;
  assign p0.ready  = grant[0];
  assign p1.ready  = grant[1];
  assign p0.rvalid = rd_pend_q & (rd_port_q == 1'b0);
  assign p1.rvalid = rd_pend_q & (rd_port_q == 1'b1);
  assign p0.rdata  = sram_dout;
  assign p1.rdata  = sram_dout;
endmodule

// File: tb/tb_sram64x4_rr_ctrl.sv
// Bench for sram64x4_rr_ctrl: behavioural SRAM macro, array-level reference model, random traffic.
module tb_sram64x4_rr_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic       sram_we;
  logic [1:0] sram_wmask;
  logic [5:0] sram_addr;
  logic [3:0] sram_din;
  logic [3:0] sram_dout;

  sram64x4_rr_ctrl_if p0_if ();
  sram64x4_rr_ctrl_if p1_if ();

  sram64x4_rr_ctrl #(
    .ADDR_WIDTH    (6),
    .DATA_WIDTH    (4),
    .WMASK_WIDTH   (2),
    .INIT_ON_RESET (1'b1)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_done),
    .p0         (p0_if),
    .p1         (p1_if),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  always #5 clk = ~clk;

  // Macro model: registered read, masked write, garbage contents at power-up.
  logic [3:0] macro_mem [64];
  initial for (int i = 0; i < 64; i++) macro_mem[i] = 4'($urandom);
  always @(posedge clk) begin
    sram_dout <= macro_mem[sram_addr];
    if (sram_we) begin
      if (sram_wmask[0]) macro_mem[sram_addr][1:0] <= sram_din[1:0];
      if (sram_wmask[1]) macro_mem[sram_addr][3:2] <= sram_din[3:2];
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model state.
  bit         known = 0;
  bit         m_init;
  int         m_cnt;
  int         m_ptr;
  int         m_pend;
  logic [3:0] m_pend_data;
  logic [3:0] ref_mem [64];

  logic       obs_ready0, obs_ready1, obs_rvalid0, obs_rvalid1, obs_done, obs_we;
  logic [3:0] obs_rdata0, obs_rdata1;
  logic [5:0] obs_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int port, input bit v, input bit we, input logic [1:0] m,
                       input logic [5:0] a, input logic [3:0] d);
    if (port == 0) begin
      p0_if.valid = v; p0_if.we = we; p0_if.wmask = m; p0_if.addr = a; p0_if.din = d;
    end else begin
      p1_if.valid = v; p1_if.we = we; p1_if.wmask = m; p1_if.addr = a; p1_if.din = d;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'b00, 6'd0, 4'h0);
    drive(1, 0, 0, 2'b00, 6'd0, 4'h0);
  endtask

  // Check one cycle against the model, then advance the model across the next edge.
  task automatic cycle();
    int         win;
    bit         w_we;
    logic [1:0] w_m;
    logic [5:0] w_a;
    logic [3:0] w_d;
    @(negedge clk);
    obs_ready0 = p0_if.ready;  obs_ready1 = p1_if.ready;
    obs_rvalid0 = p0_if.rvalid; obs_rvalid1 = p1_if.rvalid;
    obs_rdata0 = p0_if.rdata;  obs_rdata1 = p1_if.rdata;
    obs_done = init_done; obs_addr = sram_addr; obs_we = sram_we;
    win = -1;
    if (known && !m_init) begin
      if (p0_if.valid && p1_if.valid) win = m_ptr;
      else if (p0_if.valid) win = 0;
      else if (p1_if.valid) win = 1;
    end
    if (win == 0) begin
      w_we = p0_if.we; w_m = p0_if.wmask; w_a = p0_if.addr; w_d = p0_if.din;
    end else if (win == 1) begin
      w_we = p1_if.we; w_m = p1_if.wmask; w_a = p1_if.addr; w_d = p1_if.din;
    end else begin
      w_we = 0; w_m = 2'b00; w_a = 6'd0; w_d = 4'h0;
    end
    if (known) begin
      chk("init_done", init_done, !m_init);
      if (m_init) begin
        chk("init_ready0", p0_if.ready, 0);
        chk("init_ready1", p1_if.ready, 0);
        chk("init_we", sram_we, 1);
        chk("init_wmask", sram_wmask, 2'b11);
        chk("init_addr", sram_addr, m_cnt);
        chk("init_din", sram_din, 0);
      end else begin
        chk("ready0", p0_if.ready, win == 0);
        chk("ready1", p1_if.ready, win == 1);
        chk("sram_we", sram_we, w_we);
        chk("sram_wmask", sram_wmask, w_m);
        chk("sram_addr", sram_addr, w_a);
        chk("sram_din", sram_din, w_d);
      end
      chk("rvalid0", p0_if.rvalid, m_pend == 0);
      chk("rvalid1", p1_if.rvalid, m_pend == 1);
      if (m_pend == 0) chk("rdata0", p0_if.rdata, m_pend_data);
      if (m_pend == 1) chk("rdata1", p1_if.rdata, m_pend_data);
    end
    if (rst) begin
      known = 1; m_init = 1; m_cnt = 0; m_ptr = 0; m_pend = -1;
      for (int i = 0; i < 64; i++) ref_mem[i] = 4'h0;
    end else if (known) begin
      m_pend = -1;
      if (m_init) begin
        m_cnt++;
        if (m_cnt == 64) m_init = 0;
      end else if (win >= 0) begin
        if (w_we) begin
          if (w_m[0]) ref_mem[w_a][1:0] = w_d[1:0];
          if (w_m[1]) ref_mem[w_a][3:2] = w_d[3:2];
        end else begin
          m_pend = win;
          m_pend_data = ref_mem[w_a];
        end
        m_ptr = 1 - win;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (obs_done === 1'b1) return;
    end
    chk("init_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1; idle();
    cycle();
    rst = 0;
    wait_init();
  endtask

  initial begin
    int low;
    bit [3:0] alt;
    rst = 1; idle();
    cycle(); cycle();
    rst = 0;

    // Zero-fill lasts exactly 64 cycles.
    low = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (obs_done === 1'b1) break;
      low++;
    end
    chk("init_len", low, 64);

    drive(0, 1, 0, 2'b00, 6'd7, 4'h0); cycle();
    idle(); cycle();
    chk("fill_rvalid", obs_rvalid0, 1);
    chk("fill_rdata", obs_rdata0, 4'h0);

    // Full write then read-back on p0.
    drive(0, 1, 1, 2'b11, 6'd5, 4'hA); cycle();
    chk("wr_ready", obs_ready0, 1);
    drive(0, 1, 0, 2'b00, 6'd5, 4'h0); cycle();
    chk("rd_ready", obs_ready0, 1);
    idle(); cycle();
    chk("rd_rvalid0", obs_rvalid0, 1);
    chk("rd_rdata0", obs_rdata0, 4'hA);
    chk("rd_rvalid1", obs_rvalid1, 0);

    // Upper-lane-only write: A -> 6.
    drive(0, 1, 1, 2'b10, 6'd5, 4'h5); cycle();
    drive(0, 1, 0, 2'b00, 6'd5, 4'h0); cycle();
    idle(); cycle();
    chk("mask_rdata", obs_rdata0, 4'h6);

    // Continuous contention from reset alternates p0,p1,p0,p1.
    do_reset();
    drive(0, 1, 0, 2'b00, 6'd1, 4'h0);
    drive(1, 1, 0, 2'b00, 6'd2, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      alt[i] = obs_ready0;
      if (i > 0) chk("alt_rvalid1", obs_rvalid1, i % 2 == 0);
    end
    chk("alt_grants", alt, 4'b0101);

    // p1 alone three times, then p0 wins the tie.
    drive(0, 0, 0, 2'b00, 6'd0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("p1_alone", obs_ready1, 1);
    end
    drive(0, 1, 0, 2'b00, 6'd3, 4'h0); cycle();
    chk("tie_p0", obs_ready0, 1);
    idle(); cycle();

    // Reset the cycle after a read is accepted.
    drive(0, 1, 1, 2'b11, 6'd9, 4'hF); cycle();
    drive(0, 1, 0, 2'b00, 6'd9, 4'h0); cycle();
    idle(); rst = 1; cycle();
    chk("pre_rst_rdata", obs_rdata0, 4'hF);
    rst = 0; cycle();
    chk("rst_rvalid0", obs_rvalid0, 0);
    chk("rst_init_addr", obs_addr, 6'd0);
    chk("rst_init_we", obs_we, 1);
    wait_init();
    drive(0, 1, 0, 2'b00, 6'd9, 4'h0); cycle();
    idle(); cycle();
    chk("rst_cleared", obs_rdata0, 4'h0);

    // Random mixed traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int p = 0; p < 2; p++)
        drive(p, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 2'($urandom),
              6'($urandom_range(0, 7)), 4'($urandom));
      cycle();
    end
    rst = 0; idle();
    cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
